// File: rtl/encoder_event_fifo.sv
// Event FIFO that buffers 2-bit priority-encoder codes with first-word fall-through output.
// Optional macro ENCODER_FIFO_DEDUP_EN drops events repeating the last accepted code.
module encoder_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              in_q,
    input  logic                    in_valid,
    output logic [1:0]              out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [1:0]    storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          pop;
    logic          event_ok;
    logic          push;
    logic          drop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

`ifdef ENCODER_FIFO_DEDUP_EN
    logic [1:0] last_q;
    logic       last_set;

    // A repeat of the last accepted code is swallowed: neither a push nor a drop.
    assign event_ok = in_valid && !(last_set && (in_q == last_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q   <= 2'b00;
            last_set <= 1'b0;
        end else if (push) begin
            last_q   <= in_q;
            last_set <= 1'b1;
        end
    end
`else
    assign event_ok = in_valid;
`endif

    assign out_valid = (count != '0);
    assign full      = (count == CNT_FULL);
    assign pop       = out_valid && out_ready;
    // A pop at the same edge frees the slot, so a full FIFO still accepts.
    assign push      = event_ok && (!full || pop);
    assign drop      = event_ok && full && !pop;
    assign out_q     = out_valid ? storage[rd_ptr] : 2'b00;

    // Storage is data only; its contents are irrelevant while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= in_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    // Set wins over clear when a drop coincides with clr_overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
